cm_bus_sequencer: RTL and testbench



---
 rtl/cm_pkg.sv | 21 ++
 rtl/cm_sync.sv | 25 ++
 rtl/cm_bus_sequencer.sv | 163 ++++++++++++++++
 tb/tb_cm_bus_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared definitions for the CodeMasters (mapper 71) CPU-bus sequencer:
// FSM state encoding, mirroring register encoding and the ROM-space
// address decode constants (expressed on CPU A14..A0).
package cm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_COMMIT = 2'd2
    } cm_state_e;

    // mirroring = {forced, value}
    localparam logic MIRR_HV     = 1'b0;  // value selects H(0)/V(1)
    localparam logic MIRR_SINGLE = 1'b1;  // value selects the single-screen page

    // Address decode on A14..A0 of a ROM-space cycle
    localparam int          BANK_SEL_BIT = 14;       // $C000-$FFFF
    localparam logic [2:0]  MIRR_SEL     = 3'b001;   // $9000-$9FFF
    localparam logic [14:0] RESET_VEC    = 15'h7FFC; // $FFFC

endpackage

// File: rtl/cm_sync.sv
// Multi-flop synchronizer for one asynchronous bus strobe.
// Ports: clk, rst_n (async, active low), d (raw input), q (synchronized).
// RESET_VAL lets the caller choose the level the chain holds during reset,
// so that a strobe already active at reset release does not look like a
// fresh edge.
module cm_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= {SYNC_STAGES{RESET_VAL}};
        else        ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/cm_bus_sequencer.sv
// Clocked CPU-bus front end for the CodeMasters (mapper 71) board.
// Oversamples M2, /ROMSEL, R/W, address and data on clk, qualifies complete
// ROM-space cycles and updates the PRG bank / mirroring registers.
// Ports:
//   clk, rst_n            oscillator clock, async active-low reset
//   m2, romsel            raw CPU M2 and /ROMSEL
//   cpu_rw_in/addr/data   raw CPU R/W, A14..A0, D7..D0
//   cpu_bank              16 KiB PRG bank for $8000-$BFFF
//   mirroring             {forced, value}
//   cfg_wr                one-clk pulse on bank or mirroring write
//   cycle_err             one-clk pulse when a too-short M2 high is dropped
//   led                   synchronized ~romsel
module cm_bus_sequencer
    import cm_pkg::*;
#(
    parameter logic MIRRORING_VERTICAL = 1'b1,
    parameter int   SYNC_STAGES        = 2,
    parameter int   M2_MIN_HIGH        = 2,
    parameter logic RESET_VEC_RESTORE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m2,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic [3:0]  cpu_bank,
    output logic [1:0]  mirroring,
    output logic        cfg_wr,
    output logic        cycle_err,
    output logic        led
);

    localparam int          CNT_W        = $clog2(M2_MIN_HIGH + 1);
    localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(M2_MIN_HIGH);
    localparam logic [1:0]  MIRR_DEFAULT = {MIRR_HV, MIRRORING_VERTICAL};
    localparam int          BUS_W        = 1 + 15 + 5;

    // Only D4..D0 are ever decoded.
    logic unused_data;
    assign unused_data = ^cpu_data_in[7:5];

    // Synchronizers hold 1 in reset: M2 high at release then shows no rising
    // edge, and /ROMSEL reads as idle (led off).
    logic m2_s, m2_d, romsel_s;

    cm_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_m2 (
        .clk(clk), .rst_n(rst_n), .d(m2), .q(m2_s));

    cm_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_romsel (
        .clk(clk), .rst_n(rst_n), .d(romsel), .q(romsel_s));

    // Bus lines are delayed by the same depth as M2 so a capture taken at the
    // last synchronized M2-high clk sees the bus from the last raw M2-high clk.
    logic [SYNC_STAGES-1:0][BUS_W-1:0] bus_dly;
    logic [BUS_W-1:0] bus_now;

    assign bus_now = bus_dly[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_dly <= '0;
            m2_d    <= 1'b1;
        end else begin
            bus_dly <= {bus_dly[SYNC_STAGES-2:0], {cpu_rw_in, cpu_addr_in, cpu_data_in[4:0]}};
            m2_d    <= m2_s;
        end
    end

    logic m2_rise;
    assign m2_rise = m2_s & ~m2_d;
    assign led     = ~romsel_s;

    cm_state_e        state, state_nxt;
    logic [CNT_W-1:0] hi_cnt, hi_nxt;
    logic             cap_en;
    logic             cap_rw, cap_romsel;
    logic [14:0]      cap_addr;
    logic [4:0]       cap_data;
    logic [3:0]       bank_nxt;
    logic [1:0]       mirr_nxt;
    logic             cfg_nxt, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hi_cnt     <= '0;
            cap_rw     <= 1'b0;
            cap_romsel <= 1'b0;
            cap_addr   <= '0;
            cap_data   <= '0;
            cpu_bank   <= '0;
            mirroring  <= MIRR_DEFAULT;
            cfg_wr     <= 1'b0;
            cycle_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hi_cnt    <= hi_nxt;
            cpu_bank  <= bank_nxt;
            mirroring <= mirr_nxt;
            cfg_wr    <= cfg_nxt;
            cycle_err <= err_nxt;
            if (cap_en) begin
                {cap_rw, cap_addr, cap_data} <= bus_now;
                cap_romsel                   <= romsel_s;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_cnt;
        cap_en    = 1'b0;
        bank_nxt  = cpu_bank;
        mirr_nxt  = mirroring;
        cfg_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m2_rise) begin
                    state_nxt = ST_HIGH;
                    hi_nxt    = CNT_W'(1);
                    cap_en    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (m2_s) begin
                    cap_en = 1'b1;
                    if (hi_cnt < HI_MAX) hi_nxt = hi_cnt + 1'b1;
                end else if (hi_cnt >= HI_MAX) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (!cap_romsel) begin
                    if (!cap_rw && cap_addr[BANK_SEL_BIT]) begin
                        bank_nxt = cap_data[3:0];
                        cfg_nxt  = 1'b1;
                    end else if (!cap_rw && cap_addr[14:12] == MIRR_SEL) begin
                        mirr_nxt = {MIRR_SINGLE, cap_data[4]};
                        cfg_nxt  = 1'b1;
                    end else if (cap_rw && cap_addr == RESET_VEC && RESET_VEC_RESTORE) begin
                        mirr_nxt = MIRR_DEFAULT;
                    end
                end
                // A rise already visible here starts the next cycle directly.
                if (m2_rise) begin
                    state_nxt = ST_HIGH;
                    hi_nxt    = CNT_W'(1);
                    cap_en    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cm_bus_sequencer.sv
module tb_cm_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m2, romsel, cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic [3:0]  cpu_bank, cpu_bank_nr;
    logic [1:0]  mirroring, mirroring_nr;
    logic        cfg_wr, cycle_err, led;
    logic        cfg_wr_nr, cycle_err_nr, led_nr;

    always #5 clk = ~clk;

    cm_bus_sequencer dut (
        .clk(clk), .rst_n(rst_n), .m2(m2), .romsel(romsel),
        .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .cpu_bank(cpu_bank), .mirroring(mirroring), .cfg_wr(cfg_wr),
        .cycle_err(cycle_err), .led(led));

    cm_bus_sequencer #(.RESET_VEC_RESTORE(1'b0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .m2(m2), .romsel(romsel),
        .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
        .cpu_bank(cpu_bank_nr), .mirroring(mirroring_nr), .cfg_wr(cfg_wr_nr),
        .cycle_err(cycle_err_nr), .led(led_nr));

    int checks = 0;
    int errors = 0;
    int cfg_cnt = 0;
    int err_cnt = 0;

    // Pulse counters, sampled well after the active edge.
    always @(posedge clk) begin
        #2;
        if (cfg_wr === 1'b1) cfg_cnt++;
        if (cycle_err === 1'b1) err_cnt++;
    end

    typedef struct {
        logic [3:0] bank;
        logic [1:0] mirr;
        logic [1:0] mirr_nr;
        int         cfg;
        int         err;
    } exp_t;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rs;
        int          hi;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One CPU cycle: M2 high for hi clks, then junk on the bus (a would-be
    // bank write) while M2 is low, then settle and compare with the scoreboard.
    task automatic run_cycle(input string name, input logic rw, input logic [15:0] addr,
                             input logic [7:0] data, input logic rs, input int hi, input exp_t e);
        int c0, e0;
        exp_t x;
        sb.push_back(e);
        c0 = cfg_cnt;
        e0 = err_cnt;
        @(negedge clk);
        cpu_rw_in = rw; cpu_addr_in = addr[14:0]; cpu_data_in = data; romsel = rs; m2 = 1'b1;
        repeat (hi) @(negedge clk);
        m2 = 1'b0;
        cpu_rw_in = 1'b0; cpu_addr_in = 15'h4000; cpu_data_in = 8'h0F; romsel = 1'b0;
        repeat (8) @(negedge clk);
        romsel = 1'b1;
        x = sb.pop_front();
        chk({name, " bank"}, 32'(cpu_bank), 32'(x.bank));
        chk({name, " mirr"}, 32'(mirroring), 32'(x.mirr));
        chk({name, " mirr_nr"}, 32'(mirroring_nr), 32'(x.mirr_nr));
        chk({name, " cfg_wr"}, 32'(cfg_cnt - c0), 32'(x.cfg));
        chk({name, " cycle_err"}, 32'(err_cnt - e0), 32'(x.err));
    endtask

    initial begin
        int c0;
        vt[0]  = '{1'b0, 16'hC000, 8'h05, 1'b0, 6, '{4'h5, 2'b01, 2'b01, 1, 0}};
        vt[1]  = '{1'b0, 16'h9000, 8'h10, 1'b0, 4, '{4'h5, 2'b11, 2'b11, 1, 0}};
        vt[2]  = '{1'b0, 16'h9000, 8'h00, 1'b0, 4, '{4'h5, 2'b10, 2'b10, 1, 0}};
        vt[3]  = '{1'b0, 16'h9000, 8'h10, 1'b0, 4, '{4'h5, 2'b11, 2'b11, 1, 0}};
        vt[4]  = '{1'b1, 16'hFFFC, 8'h00, 1'b0, 4, '{4'h5, 2'b01, 2'b11, 0, 0}};
        vt[5]  = '{1'b0, 16'hC000, 8'h0A, 1'b0, 1, '{4'h5, 2'b01, 2'b11, 0, 1}};
        vt[6]  = '{1'b0, 16'h8000, 8'hFF, 1'b0, 4, '{4'h5, 2'b01, 2'b11, 0, 0}};
        vt[7]  = '{1'b0, 16'h4000, 8'h0E, 1'b1, 4, '{4'h5, 2'b01, 2'b11, 0, 0}};
        vt[8]  = '{1'b0, 16'hF123, 8'h09, 1'b0, 2, '{4'h9, 2'b01, 2'b11, 1, 0}};
        vt[9]  = '{1'b0, 16'hA000, 8'h1F, 1'b0, 3, '{4'h9, 2'b01, 2'b11, 0, 0}};
        vt[10] = '{1'b1, 16'hC000, 8'h03, 1'b0, 3, '{4'h9, 2'b01, 2'b11, 0, 0}};
        vt[11] = '{1'b0, 16'h9FFF, 8'hEF, 1'b0, 3, '{4'h9, 2'b10, 2'b10, 1, 0}};
        vt[12] = '{1'b1, 16'hFFFC, 8'h00, 1'b1, 3, '{4'h9, 2'b10, 2'b10, 0, 0}};
        vt[13] = '{1'b1, 16'hFFFC, 8'h00, 1'b0, 2, '{4'h9, 2'b01, 2'b10, 0, 0}};

        rst_n = 1'b0; m2 = 1'b0; romsel = 1'b1;
        cpu_rw_in = 1'b1; cpu_addr_in = '0; cpu_data_in = '0;
        #12;
        chk("reset bank", 32'(cpu_bank), 32'h0);
        chk("reset mirr", 32'(mirroring), 32'h1);
        chk("reset cfg_wr", 32'(cfg_wr), 32'h0);
        chk("reset cycle_err", 32'(cycle_err), 32'h0);
        chk("reset led", 32'(led), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // led follows ~romsel after synchronization
        romsel = 1'b0;
        repeat (4) @(negedge clk);
        chk("led on", 32'(led), 32'h1);
        romsel = 1'b1;
        repeat (4) @(negedge clk);
        chk("led off", 32'(led), 32'h0);

        for (int i = 0; i < 14; i++)
            run_cycle($sformatf("vec%0d", i), vt[i].rw, vt[i].addr, vt[i].data,
                      vt[i].rs, vt[i].hi, vt[i].e);

        // Back-to-back cycles: M2 low for a single clk, next rise lands in COMMIT.
        c0 = cfg_cnt;
        @(negedge clk);
        cpu_rw_in = 1'b0; cpu_addr_in = 15'h4000; cpu_data_in = 8'h01; romsel = 1'b0; m2 = 1'b1;
        repeat (3) @(negedge clk);
        m2 = 1'b0; cpu_data_in = 8'h02;
        @(negedge clk);
        m2 = 1'b1;
        repeat (3) @(negedge clk);
        m2 = 1'b0; cpu_data_in = 8'h0D;
        repeat (8) @(negedge clk);
        romsel = 1'b1;
        chk("b2b bank", 32'(cpu_bank), 32'h2);
        chk("b2b cfg_wr", 32'(cfg_cnt - c0), 32'd2);

        // Non-default mirroring before the reset test.
        run_cycle("pre_rst", 1'b0, 16'h9000, 8'h10, 1'b0, 4, '{4'h2, 2'b11, 2'b11, 1, 0});

        // Reset in the middle of a $C000=07 write; released while M2 still high.
        c0 = cfg_cnt;
        @(negedge clk);
        cpu_rw_in = 1'b0; cpu_addr_in = 15'h4000; cpu_data_in = 8'h07; romsel = 1'b0; m2 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst bank", 32'(cpu_bank), 32'h0);
        chk("rst mirr", 32'(mirroring), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        m2 = 1'b0;
        repeat (8) @(negedge clk);
        romsel = 1'b1;
        chk("post-rst bank", 32'(cpu_bank), 32'h0);
        chk("post-rst cfg_wr", 32'(cfg_cnt - c0), 32'd0);
        run_cycle("after_rst", 1'b0, 16'hC000, 8'h03, 1'b0, 4, '{4'h3, 2'b01, 2'b01, 1, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
